// File: rtl/addsub_seq.sv
// addsub_seq: multi-cycle adder/subtractor that walks WIDTH-bit operands
// CHUNK bits per cycle, LSB chunk first, through a registered carry/borrow.
// Valid/ready on both sides; produces carry/borrow-out, signed overflow and
// zero flags alongside the result.
module addsub_seq #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             ci,
  input  logic             sub_select,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             co,
  output logic             ovf,
  output logic             zero
);

  localparam int NCHUNK = WIDTH / CHUNK;
  // Keep the index at least one bit wide so NCHUNK == 1 still elaborates.
  localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IW-1:0]    LAST = IW'(NCHUNK - 1);
  localparam logic [WIDTH-1:0] MASK = WIDTH'({CHUNK{1'b1}});

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             sub_q, sub_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             co_q, co_d, ovf_q, ovf_d, zero_q, zero_d;

  // Chunk datapath signals.
  logic [31:0]      sh;
  logic [CHUNK-1:0] a_ch, b_ch;
  logic [CHUNK:0]   tmp;
  logic [WIDTH-1:0] res_nx;

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign out       = out_q;
  assign co        = co_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

  // One chunk of add/sub; chunks are selected and merged with shifts so the
  // working result only changes in the chunk currently being processed.
  always_comb begin
    sh   = 32'(idx_q) * 32'(CHUNK);
    a_ch = CHUNK'(a_q >> sh);
    b_ch = CHUNK'(b_q >> sh);
    if (sub_q)
      tmp = {1'b0, a_ch} - {1'b0, b_ch} - (CHUNK+1)'(carry_q);
    else
      tmp = {1'b0, a_ch} + {1'b0, b_ch} + (CHUNK+1)'(carry_q);
    res_nx = (res_q & ~(MASK << sh)) | (WIDTH'(tmp[CHUNK-1:0]) << sh);
  end

  // Next-state and register-update logic for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sub_d   = sub_q;
    res_d   = res_q;
    out_d   = out_q;
    co_d    = co_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          a_d     = in1;
          b_d     = in2;
          sub_d   = sub_select;
          carry_d = ci;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        res_d   = res_nx;
        carry_d = tmp[CHUNK];
        if (idx_q == LAST) begin
          state_d = DONE;
          out_d   = res_nx;
          co_d    = tmp[CHUNK];
          zero_d  = (res_nx == '0);
          // Add overflows when like-signed operands give an unlike sign;
          // sub overflows when unlike-signed operands flip away from in1.
          if (sub_q)
            ovf_d = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (res_nx[WIDTH-1] != a_q[WIDTH-1]);
          else
            ovf_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (res_nx[WIDTH-1] != a_q[WIDTH-1]);
        end else begin
          idx_d = IW'(idx_q + 1'b1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset aborts any operation in flight and clears results.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      res_q   <= '0;
      out_q   <= '0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sub_q   <= sub_d;
      res_q   <= res_d;
      out_q   <= out_d;
      co_q    <= co_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

endmodule

// File: doc/addsub_seq.md
Name: addsub_seq

Overview:
- Parametrised, multi-cycle adder-subtractor with carry/borrow in and out.
- Processes WIDTH-bit operands CHUNK bits per cycle through a registered carry/borrow chain.
- Uses valid/ready handshakes on both input and output.
- Adds signed-overflow and zero flags. Serves as the arithmetic core for wide-datapath units where a full-width carry chain would not meet timing.

Parameters:
- WIDTH, 16, operand/result width in bits; must be an integer multiple of CHUNK.
- CHUNK, 4, bits processed per cycle; NCHUNK = WIDTH/CHUNK cycles per operation.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  operand set valid.
- in_ready  output  1  block can accept operands.
- in1  input  WIDTH  minuend / addend A.
- in2  input  WIDTH  subtrahend / addend B.
- ci  input  1  carry-in (add) or borrow-in (sub).
- sub_select  input  1  1 = subtract, 0 = add.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out  output  WIDTH  result.
- co  output  1  carry-out (add) or borrow-out (sub).
- ovf  output  1  signed two's-complement overflow.
- zero  output  1  out == 0.

Behaviour:
- Interface: one clock, clk; synchronous active-high reset, rst.
- Reset (rst high at an edge):
  - state goes to IDLE; chunk index = 0.
  - out, co, ovf, zero = 0; out_valid = 0.
  - in_ready = 0 while rst is high.
- FSM states IDLE, RUN, DONE:
  - in_ready = (state == IDLE) && !rst.
  - out_valid = (state == DONE).
- IDLE:
  - On in_valid && in_ready, register in1, in2, sub_select.
  - Load carry register with ci; idx = 0; go to RUN.
  - Otherwise stay in IDLE.
- RUN (one chunk per cycle, LSB chunk first):
  - Let a = in1[idx*CHUNK +: CHUNK] and b = in2[idx*CHUNK +: CHUNK].
  - Add: tmp[CHUNK:0] = a + b + carry.
  - Sub: tmp[CHUNK:0] = a - b - carry. tmp[CHUNK] is the borrow.
  - Write tmp[CHUNK-1:0] into the result chunk idx; carry <= tmp[CHUNK].
  - If idx == NCHUNK-1: go to DONE and latch co (final carry/borrow), ovf and zero. Otherwise idx++.
- Latency:
  - out_valid rises exactly NCHUNK cycles after the accepting edge.
  - NCHUNK = 1 (CHUNK = WIDTH) gives a single RUN cycle.
- Flags (from registered operands and full result):
  - ovf, add: sign(in1) == sign(in2) && sign(out) != sign(in1).
  - ovf, sub: sign(in1) != sign(in2) && sign(out) != sign(in1).
  - ci is included in the result used for these checks.
  - zero = (out == 0).
- DONE:
  - out, co, ovf, zero held stable.
  - On out_ready, return to IDLE. in_ready does not assert in the same cycle as the output handshake (no bypass).
  - Minimum issue interval is NCHUNK + 2 cycles.
- Input handling:
  - in1/in2/ci/sub_select changes while in RUN or DONE are ignored.
  - in_valid while busy is not accepted.
- Result outputs:
  - Updated only when entering DONE.
  - Between operations they keep the last result. Consumers use them only while out_valid is high.
- Reset mid-operation: the operation is aborted. The next cycle is IDLE with outputs cleared, and no out_valid is produced for the aborted operation.
- Arithmetic: all chunks are treated as unsigned; wrap-around is modulo 2^WIDTH.

Test Plan:
- WIDTH=16, CHUNK=4, add 0x00FF + 0x0001, ci=0 -> out=0x0100, co=0, ovf=0, zero=0; out_valid exactly 4 cycles after acceptance.
- Add 0xFFFF + 0x0000, ci=1 -> out=0x0000, co=1, zero=1, ovf=0. Add 0x7FFF + 0x0001, ci=0 -> out=0x8000, ovf=1, co=0.
- Sub 0x0000 - 0x0001, ci=0 -> out=0xFFFF, co=1 (borrow), ovf=0. Sub 0x8000 - 0x0001, ci=0 -> out=0x7FFF, ovf=1, co=0. Sub 0x0005 - 0x0003, ci=1 -> out=0x0001, co=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out/co/ovf/zero stable, in_ready=0, new in_valid ignored. Then out_ready=1 -> IDLE next cycle, and in_ready=1 the cycle after the handshake.
- Assert rst during the 2nd RUN cycle -> next cycle IDLE, out=0, flags 0, out_valid never asserted. A new operation afterwards completes correctly.
- Instance with CHUNK=WIDTH=16: add 0x1234 + 0x4321 -> out=0x5555, out_valid 1 cycle after acceptance. Repeat with WIDTH=8, CHUNK=2: sub 0x10 - 0x20 -> out=0xF0, co=1, 4-cycle latency.
